// File: rtl/toast_branch_unit.sv
`default_nettype none
// ============================================================================
// Module   : toast_branch_unit
// Brief    : EX-stage branch target computation, direct-mapped BTB with 2-bit
//            counters for IF prediction, and registered mispredict redirect.
// Revision : 1.0
// ============================================================================
module toast_branch_unit #(
  parameter int XLEN    = 32,
  parameter int ENTRIES = 16,
  parameter int IDX     = $clog2(ENTRIES),
  parameter int TAGW    = XLEN - 2 - IDX
) (
  input  logic            clk_i,
  input  logic            resetn_i,
  input  logic [XLEN-1:0] if_pc_i,
  output logic            pred_taken_o,
  output logic [XLEN-1:0] pred_target_o,
  input  logic            ex_valid_i,
  input  logic [1:0]      ex_branch_op_i,
  input  logic [XLEN-1:0] ex_pc_i,
  input  logic [XLEN-1:0] ex_regdata_i,
  input  logic [XLEN-1:0] ex_imm_i,
  input  logic            ex_cond_taken_i,
  input  logic            ex_pred_taken_i,
  input  logic [XLEN-1:0] ex_pred_target_i,
  input  logic            btb_flush_i,
  output logic [XLEN-1:0] ex_target_o,
  output logic            redirect_valid_o,
  output logic [XLEN-1:0] redirect_pc_o
);

  typedef enum logic [1:0] {
    OP_NONE = 2'b00,
    OP_COND = 2'b01,
    OP_JALR = 2'b10,
    OP_JAL  = 2'b11
  } branch_op_e;

  localparam logic [XLEN-1:0] C_PC_STEP = XLEN'(4);

  logic            r_valid  [ENTRIES];
  logic [TAGW-1:0] r_tag    [ENTRIES];
  logic [XLEN-1:0] r_target [ENTRIES];
  logic [1:0]      r_ctr    [ENTRIES];
  logic            r_jump   [ENTRIES];

  logic            r_redirect_valid;
  logic [XLEN-1:0] r_redirect_pc;

  branch_op_e      w_op;
  logic [XLEN-1:0] w_pc_rel;
  logic [XLEN-1:0] w_jalr_sum;
  logic [XLEN-1:0] w_target;
  logic [XLEN-1:0] w_correct_pc;
  logic            w_taken;
  logic            w_upd;
  logic            w_mispredict;
  logic [IDX-1:0]  w_if_idx;
  logic [TAGW-1:0] w_if_tag;
  logic            w_if_hit;
  logic [IDX-1:0]  w_ex_idx;
  logic [TAGW-1:0] w_ex_tag;
  logic            w_ex_hit;
  logic            w_unused_bits;

  // IF lookup: reads registered state only, so same-cycle updates are not bypassed
  assign w_if_idx      = if_pc_i[IDX+1:2];
  assign w_if_tag      = if_pc_i[XLEN-1:IDX+2];
  assign w_if_hit      = r_valid[w_if_idx] && (r_tag[w_if_idx] == w_if_tag);
  assign pred_taken_o  = w_if_hit && (r_jump[w_if_idx] || r_ctr[w_if_idx][1]);
  assign pred_target_o = pred_taken_o ? r_target[w_if_idx] : '0;

  assign w_op       = branch_op_e'(ex_branch_op_i);
  assign w_pc_rel   = ex_pc_i + ex_imm_i;
  assign w_jalr_sum = ex_regdata_i + ex_imm_i;

  always_comb begin
    w_target = '0;
    w_taken  = 1'b0;
    case (w_op)
      OP_COND: begin
        w_target = w_pc_rel;
        w_taken  = ex_cond_taken_i;
      end
      OP_JALR: begin
        w_target = {w_jalr_sum[XLEN-1:1], 1'b0};
        w_taken  = 1'b1;
      end
      OP_JAL: begin
        w_target = w_pc_rel;
        w_taken  = 1'b1;
      end
      default: begin
        w_target = '0;
        w_taken  = 1'b0;
      end
    endcase
  end

  assign ex_target_o  = w_target;
  assign w_upd        = ex_valid_i && (w_op != OP_NONE);
  assign w_mispredict = w_upd && ((w_taken != ex_pred_taken_i) ||
                                  (w_taken && (ex_pred_target_i != w_target)));
  assign w_correct_pc = w_taken ? w_target : (ex_pc_i + C_PC_STEP);

  assign w_ex_idx = ex_pc_i[IDX+1:2];
  assign w_ex_tag = ex_pc_i[XLEN-1:IDX+2];
  assign w_ex_hit = r_valid[w_ex_idx] && (r_tag[w_ex_idx] == w_ex_tag);

  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      for (int i = 0; i < ENTRIES; i++) begin
        r_valid[i]  <= 1'b0;
        r_tag[i]    <= '0;
        r_target[i] <= '0;
        r_ctr[i]    <= 2'b00;
        r_jump[i]   <= 1'b0;
      end
    end else if (btb_flush_i) begin
      // Flush takes priority over any update resolving in the same cycle
      for (int i = 0; i < ENTRIES; i++) begin
        r_valid[i] <= 1'b0;
      end
    end else if (w_upd) begin
      if (w_ex_hit) begin
        if (w_taken) begin
          r_target[w_ex_idx] <= w_target;
          if (r_ctr[w_ex_idx] != 2'b11) r_ctr[w_ex_idx] <= r_ctr[w_ex_idx] + 2'd1;
        end else if (r_ctr[w_ex_idx] != 2'b00) begin
          r_ctr[w_ex_idx] <= r_ctr[w_ex_idx] - 2'd1;
        end
        r_jump[w_ex_idx] <= (w_op != OP_COND);
      end else if (w_taken) begin
        r_valid[w_ex_idx]  <= 1'b1;
        r_tag[w_ex_idx]    <= w_ex_tag;
        r_target[w_ex_idx] <= w_target;
        r_ctr[w_ex_idx]    <= 2'b10;
        r_jump[w_ex_idx]   <= (w_op != OP_COND);
      end
    end
  end

  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      r_redirect_valid <= 1'b0;
      r_redirect_pc    <= '0;
    end else begin
      r_redirect_valid <= w_mispredict;
      r_redirect_pc    <= w_mispredict ? w_correct_pc : '0;
    end
  end

  assign redirect_valid_o = r_redirect_valid;
  assign redirect_pc_o    = r_redirect_pc;

  // Word-aligned PCs and the cleared JALR bit carry no information here
  assign w_unused_bits = ^{if_pc_i[1:0], ex_pc_i[1:0], w_jalr_sum[0]};

endmodule
`default_nettype wire

// File: tb/tb_toast_branch_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_toast_branch_unit
// Brief    : Directed bench with a redirect scoreboard for toast_branch_unit.
// Revision : 1.0
// ============================================================================
module tb_toast_branch_unit;

  logic        clk = 1'b0;
  logic        resetn_i;
  logic [31:0] if_pc_i;
  logic        pred_taken_o;
  logic [31:0] pred_target_o;
  logic        ex_valid_i;
  logic [1:0]  ex_branch_op_i;
  logic [31:0] ex_pc_i;
  logic [31:0] ex_regdata_i;
  logic [31:0] ex_imm_i;
  logic        ex_cond_taken_i;
  logic        ex_pred_taken_i;
  logic [31:0] ex_pred_target_i;
  logic        btb_flush_i;
  logic [31:0] ex_target_o;
  logic        redirect_valid_o;
  logic [31:0] redirect_pc_o;

  always #5 clk = ~clk;

  toast_branch_unit #(.XLEN(32), .ENTRIES(16)) dut (
    .clk_i            (clk),
    .resetn_i         (resetn_i),
    .if_pc_i          (if_pc_i),
    .pred_taken_o     (pred_taken_o),
    .pred_target_o    (pred_target_o),
    .ex_valid_i       (ex_valid_i),
    .ex_branch_op_i   (ex_branch_op_i),
    .ex_pc_i          (ex_pc_i),
    .ex_regdata_i     (ex_regdata_i),
    .ex_imm_i         (ex_imm_i),
    .ex_cond_taken_i  (ex_cond_taken_i),
    .ex_pred_taken_i  (ex_pred_taken_i),
    .ex_pred_target_i (ex_pred_target_i),
    .btb_flush_i      (btb_flush_i),
    .ex_target_o      (ex_target_o),
    .redirect_valid_o (redirect_valid_o),
    .redirect_pc_o    (redirect_pc_o)
  );

  typedef struct {
    int          due;
    logic [31:0] pc;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Scoreboard monitor: every presented redirect must match the oldest expectation
  always @(negedge clk) begin
    exp_t e;
    if (resetn_i === 1'b1 && redirect_valid_o === 1'b1) begin
      if (q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_redirect: got pc 0x%08h expected no redirect", redirect_pc_o);
      end else begin
        e = q.pop_front();
        chk("redirect_pc", redirect_pc_o, e.pc);
        chk("redirect_cycle", cyc, e.due);
      end
    end
  end

  task automatic ex_op(input logic [1:0] op, input logic [31:0] pc, input logic [31:0] rs1,
                       input logic [31:0] imm, input logic cond, input logic ptk,
                       input logic [31:0] ptgt, input logic [31:0] exp_tgt,
                       input logic redir, input logic [31:0] rpc, input logic flush,
                       input logic chk_lk, input logic exp_lk);
    exp_t e;
    @(negedge clk);
    ex_valid_i       = 1'b1;
    ex_branch_op_i   = op;
    ex_pc_i          = pc;
    ex_regdata_i     = rs1;
    ex_imm_i         = imm;
    ex_cond_taken_i  = cond;
    ex_pred_taken_i  = ptk;
    ex_pred_target_i = ptgt;
    btb_flush_i      = flush;
    if (chk_lk) if_pc_i = pc;
    #1;
    chk("ex_target", ex_target_o, exp_tgt);
    if (chk_lk) chk("same_cycle_lookup", {31'b0, pred_taken_o}, {31'b0, exp_lk});
    if (redir) begin
      e.due = cyc + 1;
      e.pc  = rpc;
      q.push_back(e);
    end
    @(posedge clk);
    #1;
    ex_valid_i     = 1'b0;
    ex_branch_op_i = 2'b00;
    btb_flush_i    = 1'b0;
  endtask

  task automatic lookup(input logic [31:0] pc, input logic exp_tk, input logic [31:0] exp_tgt);
    @(negedge clk);
    if_pc_i = pc;
    #1;
    chk("pred_taken", {31'b0, pred_taken_o}, {31'b0, exp_tk});
    chk("pred_target", pred_target_o, exp_tgt);
  endtask

  task automatic idle_junk();
    @(negedge clk);
    ex_valid_i       = 1'b0;
    ex_branch_op_i   = 2'b01;
    ex_pc_i          = 32'h100;
    ex_cond_taken_i  = 1'b1;
    ex_pred_taken_i  = 1'b0;
    ex_pred_target_i = 32'hDEAD_BEEC;
    @(posedge clk);
    #1;
    ex_branch_op_i = 2'b00;
  endtask

  initial begin
    resetn_i = 1'b0;
    if_pc_i = 32'h100;
    ex_valid_i = 1'b0;
    ex_branch_op_i = 2'b00;
    ex_pc_i = '0;
    ex_regdata_i = '0;
    ex_imm_i = '0;
    ex_cond_taken_i = 1'b0;
    ex_pred_taken_i = 1'b0;
    ex_pred_target_i = '0;
    btb_flush_i = 1'b0;
    #1;
    chk("reset_redirect_valid", {31'b0, redirect_valid_o}, 32'd0);
    chk("reset_redirect_pc", redirect_pc_o, 32'd0);
    repeat (2) @(negedge clk);
    resetn_i = 1'b1;
    lookup(32'h100, 1'b0, 32'h0);

    // Conditional branch learning; lookup in the update cycle sees the old miss
    ex_op(2'b01, 32'h100, 32'h0, 32'h40, 1'b1, 1'b0, 32'h0, 32'h140, 1'b1, 32'h140, 1'b0, 1'b1, 1'b0);
    idle_junk();
    lookup(32'h100, 1'b1, 32'h140);

    // Down-count 10 -> 01 -> 00 with back-to-back mispredicts
    ex_op(2'b01, 32'h100, 32'h0, 32'h40, 1'b0, 1'b1, 32'h140, 32'h140, 1'b1, 32'h104, 1'b0, 1'b0, 1'b0);
    ex_op(2'b01, 32'h100, 32'h0, 32'h40, 1'b0, 1'b1, 32'h140, 32'h140, 1'b1, 32'h104, 1'b0, 1'b0, 1'b0);
    lookup(32'h100, 1'b0, 32'h0);

    // Low saturation, then climb back 00 -> 01 -> 10
    ex_op(2'b01, 32'h100, 32'h0, 32'h40, 1'b0, 1'b0, 32'h0, 32'h140, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    ex_op(2'b01, 32'h100, 32'h0, 32'h40, 1'b1, 1'b0, 32'h0, 32'h140, 1'b1, 32'h140, 1'b0, 1'b0, 1'b0);
    lookup(32'h100, 1'b0, 32'h0);
    ex_op(2'b01, 32'h100, 32'h0, 32'h40, 1'b1, 1'b0, 32'h0, 32'h140, 1'b1, 32'h140, 1'b0, 1'b1, 1'b0);
    lookup(32'h100, 1'b1, 32'h140);

    // High saturation: 10 -> 11 -> 11 -> 10 stays predicted taken
    ex_op(2'b01, 32'h100, 32'h0, 32'h40, 1'b1, 1'b1, 32'h140, 32'h140, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    ex_op(2'b01, 32'h100, 32'h0, 32'h40, 1'b1, 1'b1, 32'h140, 32'h140, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    ex_op(2'b01, 32'h100, 32'h0, 32'h40, 1'b0, 1'b1, 32'h140, 32'h140, 1'b1, 32'h104, 1'b0, 1'b0, 1'b0);
    lookup(32'h100, 1'b1, 32'h140);

    // JALR clears bit 0; a matching prediction later gives no redirect
    ex_op(2'b10, 32'h208, 32'h2001, 32'h10, 1'b0, 1'b0, 32'h0, 32'h2010, 1'b1, 32'h2010, 1'b0, 1'b0, 1'b0);
    lookup(32'h208, 1'b1, 32'h2010);
    ex_op(2'b10, 32'h208, 32'h2001, 32'h10, 1'b0, 1'b1, 32'h2010, 32'h2010, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);

    // JAL with a negative offset
    ex_op(2'b11, 32'h304, 32'hFFFF, 32'hFFFF_FFF0, 1'b0, 1'b0, 32'h0, 32'h2F4, 1'b1, 32'h2F4, 1'b0, 1'b0, 1'b0);
    lookup(32'h304, 1'b1, 32'h2F4);

    // Aliasing: 0x140 replaces 0x100 in index 0, wrong predicted target
    ex_op(2'b01, 32'h140, 32'h0, 32'h1C0, 1'b1, 1'b1, 32'h140, 32'h300, 1'b1, 32'h300, 1'b0, 1'b0, 1'b0);
    lookup(32'h100, 1'b0, 32'h0);
    lookup(32'h140, 1'b1, 32'h300);

    // Op 00 with a valid slot and junk prediction never redirects
    ex_op(2'b00, 32'h140, 32'h55, 32'h10, 1'b1, 1'b1, 32'h999, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);

    // Flush collides with a taken update to 0x180
    ex_op(2'b01, 32'h180, 32'h0, 32'h4, 1'b1, 1'b0, 32'h0, 32'h184, 1'b1, 32'h184, 1'b1, 1'b0, 1'b0);
    lookup(32'h180, 1'b0, 32'h0);
    lookup(32'h208, 1'b0, 32'h0);
    lookup(32'h140, 1'b0, 32'h0);

    // Repopulate, then reset asynchronously while a redirect is showing
    ex_op(2'b01, 32'h100, 32'h0, 32'h40, 1'b1, 1'b0, 32'h0, 32'h140, 1'b1, 32'h140, 1'b0, 1'b0, 1'b0);
    lookup(32'h100, 1'b1, 32'h140);
    @(negedge clk);
    ex_valid_i       = 1'b1;
    ex_branch_op_i   = 2'b01;
    ex_pc_i          = 32'h100;
    ex_imm_i         = 32'h40;
    ex_cond_taken_i  = 1'b0;
    ex_pred_taken_i  = 1'b1;
    ex_pred_target_i = 32'h140;
    @(posedge clk);
    #2;
    ex_valid_i     = 1'b0;
    ex_branch_op_i = 2'b00;
    chk("pre_reset_redirect_valid", {31'b0, redirect_valid_o}, 32'd1);
    chk("pre_reset_redirect_pc", redirect_pc_o, 32'h104);
    resetn_i = 1'b0;
    #1;
    chk("async_reset_redirect_valid", {31'b0, redirect_valid_o}, 32'd0);
    chk("async_reset_redirect_pc", redirect_pc_o, 32'd0);
    chk("async_reset_pred_taken", {31'b0, pred_taken_o}, 32'd0);
    chk("async_reset_pred_target", pred_target_o, 32'd0);
    @(negedge clk);
    resetn_i = 1'b1;
    lookup(32'h100, 1'b0, 32'h0);

    repeat (3) @(negedge clk);
    chk("scoreboard_drained", q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
